// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults, entry type and index helper for the write-back merge stage.
package wb_pkg;
   localparam int NUM_CH_DEF = 2;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry_t;
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (oh[i]) r = r | 3'(i);
      return r;
   endfunction
endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: one-hot grant over held entries; round-robin when WB_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
) (
`ifdef WB_RR_ARB_EN
   input  logic              clk,
   input  logic              reset,
`endif
   input  logic [NUM_CH-1:0] held_i,
   output logic [NUM_CH-1:0] grant_o
);
`ifdef WB_RR_ARB_EN
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, idx;
   logic [7:0]       gv;
   logic [2:0]       gi;
   // scan farthest-first so the entry nearest after rr_ptr overwrites the rest
   always_comb begin
      grant_o = '0;
      idx = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_CH);
         if (held_i[idx]) begin
            grant_o = '0;
            grant_o[idx] = 1'b1;
         end
      end
      gv = '0;
      gv[NUM_CH-1:0] = grant_o;
      gi = onehot_to_idx(gv);
      rr_ptr_d = |grant_o ? gi[IDX_W-1:0] : rr_ptr_q;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) rr_ptr_q <= IDX_W'(NUM_CH - 1);
      else        rr_ptr_q <= rr_ptr_d;
`else
   assign grant_o = held_i & (~held_i + 1'b1);
`endif
endmodule

// File: rtl/wb_merge_stg.sv
// wb_merge_stg: merges NUM_CH result channels through one-entry hold buffers onto a
// registered register-file write port. Define WB_RR_ARB_EN for round-robin arbitration.
module wb_merge_stg
   import wb_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH-1:0]        ch_wb_en,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata
);
   logic [NUM_CH-1:0] held_q, held_d, grant, load;
   logic [ADDR_W-1:0] addr_q [NUM_CH];
   logic [ADDR_W-1:0] addr_d [NUM_CH];
   logic [DATA_W-1:0] data_q [NUM_CH];
   logic [DATA_W-1:0] data_d [NUM_CH];
   logic              rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_d;

   wb_arbiter #(.NUM_CH(NUM_CH)) u_arb (
`ifdef WB_RR_ARB_EN
      .clk    (clk),
      .reset  (reset),
`endif
      .held_i (held_q),
      .grant_o(grant)
   );

   // retire-only results (wb_en=0) are accepted but never buffered
   always_comb begin
      ch_ready   = flush ? '0 : (~held_q | grant);
      load       = ch_valid & ch_ready & ch_wb_en;
      held_d     = flush ? '0 : (load | (held_q & ~grant));
      rf_we_d    = !flush && (|grant);
      rf_waddr_d = rf_waddr;
      rf_wdata_d = rf_wdata;
      for (int i = 0; i < NUM_CH; i++) begin
         addr_d[i] = load[i] ? ch_addr[i*ADDR_W +: ADDR_W] : addr_q[i];
         data_d[i] = load[i] ? ch_data[i*DATA_W +: DATA_W] : data_q[i];
         if (grant[i] && !flush) begin
            rf_waddr_d = addr_q[i];
            rf_wdata_d = data_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         held_q   <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         held_q   <= held_d;
         rf_we    <= rf_we_d;
         rf_waddr <= rf_waddr_d;
         rf_wdata <= rf_wdata_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end
endmodule

// File: tb/tb_wb_merge_stg.sv
// tb_wb_merge_stg: directed vector table plus hand sequences for contention, flush and async reset.
module tb_wb_merge_stg;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  ch_valid = '0;
   logic [1:0]  ch_wb_en = '0;
   logic [1:0]  ch_ready;
   logic [5:0]  ch_addr = '0;
   logic [31:0] ch_data = '0;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        fl;
      logic [1:0]  v;
      logic [1:0]  wb;
      logic [2:0]  a0;
      logic [2:0]  a1;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [1:0]  er;
      logic        ew;
      logic [2:0]  ea;
      logic [15:0] ed;
   } vec_t;

   wb_merge_stg #(.NUM_CH(2), .DATA_W(16), .ADDR_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .ch_valid(ch_valid),
      .ch_ready(ch_ready),
      .ch_wb_en(ch_wb_en),
      .ch_addr (ch_addr),
      .ch_data (ch_data),
      .rf_we   (rf_we),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // drive at posedge+1, check ready mid-cycle, check registered outputs at next posedge+1
   task automatic cyc(input string nm, input vec_t t, input logic chk_ad);
      flush = t.fl; ch_valid = t.v; ch_wb_en = t.wb;
      ch_addr = {t.a1, t.a0}; ch_data = {t.d1, t.d0};
      n_vec++;
      #3 chk({nm, "_ready"}, 32'(ch_ready), 32'(t.er));
      @(posedge clk); #1;
      chk({nm, "_we"}, 32'(rf_we), 32'(t.ew));
      if (chk_ad) begin
         chk({nm, "_waddr"}, 32'(rf_waddr), 32'(t.ea));
         chk({nm, "_wdata"}, 32'(rf_wdata), 32'(t.ed));
      end
   endtask

   vec_t tbl [15];
   vec_t c;
   logic [1:0]  c_er [9];
   logic        c_ew [9];
   logic [15:0] c_ed [9];

   initial begin
      tbl[0]  = '{1'b0, 2'b01, 2'b01, 3'd3, 3'd0, 16'h1234, 16'h0000, 2'b11, 1'b0, 3'd0, 16'h0000};
      tbl[1]  = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b1, 3'd3, 16'h1234};
      tbl[2]  = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b0, 3'd3, 16'h1234};
      tbl[3]  = '{1'b0, 2'b01, 2'b01, 3'd1, 3'd0, 16'h0011, 16'h0000, 2'b11, 1'b0, 3'd3, 16'h1234};
      tbl[4]  = '{1'b0, 2'b01, 2'b01, 3'd2, 3'd0, 16'h0022, 16'h0000, 2'b11, 1'b1, 3'd1, 16'h0011};
      tbl[5]  = '{1'b0, 2'b01, 2'b01, 3'd4, 3'd0, 16'h0033, 16'h0000, 2'b11, 1'b1, 3'd2, 16'h0022};
      tbl[6]  = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b1, 3'd4, 16'h0033};
      tbl[7]  = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b0, 3'd4, 16'h0033};
      tbl[8]  = '{1'b0, 2'b11, 2'b10, 3'd6, 3'd5, 16'hDEAD, 16'hBEEF, 2'b11, 1'b0, 3'd4, 16'h0033};
      tbl[9]  = '{1'b0, 2'b01, 2'b00, 3'd7, 3'd0, 16'h7777, 16'h0000, 2'b11, 1'b1, 3'd5, 16'hBEEF};
      tbl[10] = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b0, 3'd5, 16'hBEEF};
      tbl[11] = '{1'b0, 2'b11, 2'b11, 3'd1, 3'd2, 16'hA1A1, 16'hB2B2, 2'b11, 1'b0, 3'd5, 16'hBEEF};
      tbl[12] = '{1'b1, 2'b11, 2'b11, 3'd6, 3'd7, 16'h5555, 16'h6666, 2'b00, 1'b0, 3'd5, 16'hBEEF};
      tbl[13] = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b0, 3'd5, 16'hBEEF};
      tbl[14] = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b11, 1'b0, 3'd5, 16'hBEEF};
`ifdef WB_RR_ARB_EN
      c_er = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11};
      c_ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      c_ed = '{16'h0, 16'h0100, 16'h0200, 16'h0101, 16'h0202, 16'h0103, 16'h0204, 16'h0105, 16'h0};
`else
      c_er = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
      c_ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      c_ed = '{16'h0, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0200, 16'h0};
`endif

      #2;
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", 32'(rf_wdata), 32'd0);
      chk("rst_ready", 32'(ch_ready), 32'd3);
      #6 reset = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) cyc($sformatf("v%0d", i), tbl[i], 1'b1);

      // both channels valid every cycle, then drain
      for (int k = 0; k < 9; k++) begin
         c = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd5, 16'h0, 16'h0, c_er[k], c_ew[k], 3'd0, c_ed[k]};
         if (k < 6) begin
            c.v = 2'b11; c.wb = 2'b11;
            c.a0 = 3'(k); c.d0 = 16'h0100 + 16'(k); c.d1 = 16'h0200 + 16'(k);
         end
         c.ea = (c_ed[k][9:8] == 2'd2) ? 3'd5 : c_ed[k][2:0];
         cyc($sformatf("cont%0d", k), c, c_ew[k]);
      end

      // asynchronous reset with entries held
      c = '{1'b0, 2'b11, 2'b11, 3'd1, 3'd2, 16'hC0C0, 16'hD0D0, 2'b11, 1'b0, 3'd0, 16'h0};
      cyc("pre_rst_load", c, 1'b0);
      c = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b01, 1'b1, 3'd0, 16'h0};
`ifdef WB_RR_ARB_EN
      c.er = 2'b10;
`endif
      cyc("pre_rst_write", c, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("arst_we", 32'(rf_we), 32'd0);
      chk("arst_waddr", 32'(rf_waddr), 32'd0);
      chk("arst_wdata", 32'(rf_wdata), 32'd0);
      chk("arst_ready", 32'(ch_ready), 32'd3);
      #2 reset = 1'b1;
      #1;
      chk("post_rst_we", 32'(rf_we), 32'd0);
      chk("post_rst_ready", 32'(ch_ready), 32'd3);
      @(posedge clk); #1;
      c = '{1'b0, 2'b11, 2'b11, 3'd3, 3'd4, 16'hE0E0, 16'hF0F0, 2'b11, 1'b0, 3'd0, 16'h0};
      cyc("rr0_load", c, 1'b0);
      c = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b01, 1'b1, 3'd3, 16'hE0E0};
      cyc("rr0_first", c, 1'b1);
      c = '{1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b11, 1'b1, 3'd4, 16'hF0F0};
      cyc("rr0_second", c, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
